// File: rtl/shift_reg_burst_pkg.sv
// Shared definitions for the universal shift register: step modes and
// burst-engine states.
package shift_reg_burst_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHL  = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_ROL  = 3'd3,
    MODE_ROR  = 3'd4,
    MODE_ASR  = 3'd5,
    MODE_LOAD = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_reg_burst_if.sv
// Control/data bundle of the shift register: the master drives operation
// requests, the slave (the register) returns contents and burst status.
interface shift_reg_burst_if #(
  parameter int W     = 8,
  parameter int CNT_W = 4
);
  logic             ce;
  logic             clr;
  logic [2:0]       mode;
  logic             d_l;
  logic             d_r;
  logic [W-1:0]     p;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     q;
  logic             so_l;
  logic             so_r;
  logic             busy;
  logic             done;

  modport master (
    output ce, clr, mode, d_l, d_r, p, start, count,
    input  q, so_l, so_r, busy, done
  );

  modport slave (
    input  ce, clr, mode, d_l, d_r, p, start, count,
    output q, so_l, so_r, busy, done
  );
endinterface

// File: rtl/shift_reg_burst_step.sv
// Combinational single-step function of the register; one copy serves both
// the free-running path and the burst path.
module shift_reg_burst_step
  import shift_reg_burst_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] q_i,
  input  mode_e        mode_i,
  input  logic         d_l_i,
  input  logic         d_r_i,
  input  logic [W-1:0] p_i,
  output logic [W-1:0] q_o
);

  // Next register value for the selected mode; reserved mode holds.
  always_comb begin
    q_o = q_i;
    case (mode_i)
      MODE_SHL:  q_o = {q_i[W-2:0], d_l_i};
      MODE_SHR:  q_o = {d_r_i, q_i[W-1:1]};
      MODE_ROL:  q_o = {q_i[W-2:0], q_i[W-1]};
      MODE_ROR:  q_o = {q_i[0], q_i[W-1:1]};
      MODE_ASR:  q_o = {q_i[W-1], q_i[W-1:1]};
      MODE_LOAD: q_o = p_i;
      default:   q_o = q_i;
    endcase
  end

endmodule

// File: rtl/shift_reg_burst.sv
// Universal shift register with a burst engine that runs COUNT steps of a
// latched mode and reports BUSY while running and a one-cycle DONE pulse.
module shift_reg_burst
  import shift_reg_burst_pkg::*;
#(
  parameter int           W         = 8,
  parameter int           CNT_W     = 4,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input logic              clk_i,
  input logic              rst_n_i,
  shift_reg_burst_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  mode_e            mode_l_q, mode_l_d;
  mode_e            step_mode;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     step_q;

  shift_reg_burst_step #(.W(W)) u_step (
    .q_i    (q_q),
    .mode_i (step_mode),
    .d_l_i  (bus.d_l),
    .d_r_i  (bus.d_r),
    .p_i    (bus.p),
    .q_o    (step_q)
  );

  // State, remaining-step counter, latched mode and register contents.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      mode_l_q <= MODE_HOLD;
      q_q      <= RESET_VAL;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      mode_l_q <= mode_l_d;
      q_q      <= q_d;
    end
  end

  // Next state: CLR beats a running burst, which beats a new START, which
  // beats free-running MODE. FIN always leaves after one cycle, even with CE
  // low, but accepts a new burst like IDLE does.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    mode_l_d  = mode_l_q;
    q_d       = q_q;
    step_mode = mode_e'(bus.mode);
    if (bus.clr) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      q_d     = RESET_VAL;
    end else if (state_q == ST_RUN) begin
      step_mode = mode_l_q;
      if (bus.ce) begin
        q_d   = step_q;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = ST_FIN;
      end
    end else begin
      if (state_q == ST_FIN) state_d = ST_IDLE;
      if (bus.ce) begin
        if (bus.start) begin
          mode_l_d = mode_e'(bus.mode);
          if (bus.count == '0) begin
            state_d = ST_FIN;
          end else begin
            q_d     = step_q;
            rem_d   = bus.count - CNT_W'(1);
            state_d = (bus.count == CNT_W'(1)) ? ST_FIN : ST_RUN;
          end
        end else begin
          q_d = step_q;
        end
      end
    end
  end

  assign bus.q    = q_q;
  assign bus.so_l = q_q[W-1];
  assign bus.so_r = q_q[0];
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_FIN);

endmodule
